// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//
// Purpose:
//   Conditions four raw push buttons (U, L, R, D) for a downstream FSM that
//   only looks at its inputs on a periodic sample strobe. Each button is
//   synchronized into the clk domain and debounced. A press produces a
//   one-cycle pulse, and that pulse is latched as a pending event until the
//   consumer acknowledges it with tick. Presses that arrive while the same
//   button is already pending are lost. They are counted in a saturating
//   drop counter.
//
// Ports:
//   clk        - system clock; all state changes on the rising edge
//   btnC       - asynchronous, active-high reset
//   btn_raw    - raw asynchronous buttons: bit0=U, bit1=L, bit2=R, bit3=D
//   tick       - one-cycle strobe marking the consumer's sample point;
//                clears pending events
//   btn_level  - debounced button levels
//   btn_press  - one-cycle pulse on each debounced rising edge
//   btn_held   - pending press events awaiting tick
//   btn_valid  - at least one event is pending
//   btn_sel    - index of the highest-priority pending button (U>L>R>D),
//                0 when nothing is pending
//   drop_cnt   - saturating count of cycles in which a press was lost
// -----------------------------------------------------------------------------
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       btnC,
  input  logic [3:0] btn_raw,
  input  logic       tick,
  output logic [3:0] btn_level,
  output logic [3:0] btn_press,
  output logic [3:0] btn_held,
  output logic       btn_valid,
  output logic [1:0] btn_sel,
  output logic [3:0] drop_cnt
);

  // The counter reaches this value on the last of DEBOUNCE_CYCLES
  // consecutive samples that disagree with the current level.
  localparam logic [23:0] LAST_COUNT = 24'(DEBOUNCE_CYCLES - 1);

  logic [3:0]  sync_meta;
  logic [3:0]  sync_out;
  logic [23:0] cnt      [4];
  logic [23:0] cnt_next [4];
  logic [3:0]  level_next;
  logic [3:0]  press_next;
  logic [3:0]  held_next;
  logic        dropping;

  // Two-flop synchronizer. This is the only logic that reads btn_raw.
  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      sync_meta <= '0;
      sync_out  <= '0;
    end else begin
      sync_meta <= btn_raw;
      sync_out  <= sync_meta;
    end
  end

  // Debounce decision per bit. The counter measures how long the synchronized
  // value has disagreed with the accepted level. Any agreement restarts the
  // count, so a short glitch is forgotten. When the count reaches its limit,
  // the new level is accepted and the count starts again from zero.
  always_comb begin
    level_next = btn_level;
    for (int i = 0; i < 4; i++) begin
      cnt_next[i] = '0;
      if (sync_out[i] != btn_level[i]) begin
        if (cnt[i] == LAST_COUNT) begin
          level_next[i] = sync_out[i];
        end else begin
          cnt_next[i] = cnt[i] + 24'd1;
        end
      end
    end
  end

  // The press pulse is registered in the same edge that raises the level.
  // This makes the pulse coincide with the first cycle the level reads 1.
  assign press_next = level_next & ~btn_level;

  // A press seen in the same cycle as tick is a new event and survives the
  // clear. A drop only happens when an event is still pending and nothing
  // is consuming it in this cycle.
  assign held_next = (btn_held & ~{4{tick}}) | btn_press;
  assign dropping  = (|(btn_press & btn_held)) & ~tick;

  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
      btn_level <= '0;
      btn_press <= '0;
      btn_held  <= '0;
      drop_cnt  <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= cnt_next[i];
      end
      btn_level <= level_next;
      btn_press <= press_next;
      btn_held  <= held_next;
      if (dropping && (drop_cnt != 4'hF)) begin
        drop_cnt <= drop_cnt + 4'd1;
      end
    end
  end

  // Priority select: bit0 (U) wins. The loop scans from bit3 down to bit0,
  // so the last assignment made is the lowest pending index.
  always_comb begin
    btn_sel = '0;
    for (int i = 3; i >= 0; i--) begin
      if (btn_held[i]) begin
        btn_sel = 2'(i);
      end
    end
  end

  assign btn_valid = |btn_held;

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//
// Purpose:
//   Self-checking bench for btn_conditioner with DEBOUNCE_CYCLES = 4. A
//   behavioural model predicts every output after each clock edge. The model
//   works from the observable rules:
//     - the level flips after DEBOUNCE_CYCLES consecutive opposite samples,
//       where each sample is the raw input from two edges earlier
//     - a press is the rising edge of the level
//     - pending events, their priority and lost events follow from that
//   The bench first runs directed scenarios, then randomized stimulus with
//   occasional asynchronous resets.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;

  localparam int DC = 4;

  logic       clk;
  logic       btnC;
  logic [3:0] btn_raw;
  logic       tick;
  logic [3:0] btn_level;
  logic [3:0] btn_press;
  logic [3:0] btn_held;
  logic       btn_valid;
  logic [1:0] btn_sel;
  logic [3:0] drop_cnt;

  int total_checks = 0;
  int bad_checks   = 0;

  // Reference model state: the expected value of each DUT register after
  // the most recent clock edge.
  logic [3:0] raw_q [$];
  logic [3:0] win   [$];
  logic [3:0] m_level;
  logic [3:0] m_press;
  logic [3:0] m_held;
  logic [3:0] m_drop;

  btn_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk      (clk),
    .btnC     (btnC),
    .btn_raw  (btn_raw),
    .tick     (tick),
    .btn_level(btn_level),
    .btn_press(btn_press),
    .btn_held (btn_held),
    .btn_valid(btn_valid),
    .btn_sel  (btn_sel),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends on its own.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_checks++;
    if (obs !== expv) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [1:0] modelSel(input logic [3:0] held);
    logic [1:0] s;
    s = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (held[i]) s = 2'(i);
    end
    return s;
  endfunction

  task automatic modelReset();
    raw_q.delete();
    raw_q.push_back(4'b0);
    raw_q.push_back(4'b0);
    win.delete();
    m_level = '0;
    m_press = '0;
    m_held  = '0;
    m_drop  = '0;
  endtask

  // Advance the model by one clock edge. raw and tk are the inputs that the
  // edge samples.
  task automatic modelEdge(input logic [3:0] raw, input logic tk);
    logic [3:0] seen;
    logic [3:0] new_level;
    bit         all_differ;
    seen = raw_q.pop_front();
    raw_q.push_back(raw);
    win.push_back(seen);
    if (win.size() > DC) void'(win.pop_front());
    new_level = m_level;
    if (win.size() == DC) begin
      for (int i = 0; i < 4; i++) begin
        all_differ = 1'b1;
        foreach (win[j]) if (win[j][i] == m_level[i]) all_differ = 1'b0;
        if (all_differ) new_level[i] = ~m_level[i];
      end
    end
    if (!tk && ((m_press & m_held) != 4'b0) && m_drop != 4'd15) m_drop = m_drop + 4'd1;
    m_held  = (tk ? 4'b0 : m_held) | m_press;
    m_press = new_level & ~m_level;
    m_level = new_level;
  endtask

  task automatic compareAll();
    checkOutput("level", 32'(btn_level), 32'(m_level));
    checkOutput("press", 32'(btn_press), 32'(m_press));
    checkOutput("held",  32'(btn_held),  32'(m_held));
    checkOutput("valid", 32'(btn_valid), 32'(m_held != 4'b0));
    checkOutput("sel",   32'(btn_sel),   32'(modelSel(m_held)));
    checkOutput("drop",  32'(drop_cnt),  32'(m_drop));
  endtask

  // Drive one cycle of inputs from a falling edge, let the rising edge act,
  // then compare on the next falling edge.
  task automatic applyStimulus(input logic [3:0] raw, input logic tk);
    btn_raw = raw;
    tick    = tk;
    modelEdge(raw, tk);
    @(negedge clk);
    tick = 1'b0;
    compareAll();
  endtask

  // Assert the reset between edges. Outputs must clear at once. Hold the
  // reset across one rising edge, then release it at the next falling edge.
  task automatic resetDut();
    btnC = 1'b1;
    tick = 1'b0;
    #1;
    modelReset();
    checkOutput("rst_async_level", 32'(btn_level), 32'd0);
    checkOutput("rst_async_held",  32'(btn_held),  32'd0);
    checkOutput("rst_async_drop",  32'(drop_cnt),  32'd0);
    checkOutput("rst_async_valid", 32'(btn_valid), 32'd0);
    @(negedge clk);
    compareAll();
    btnC = 1'b0;
  endtask

  initial begin
    logic [3:0] rnd_raw;
    int         budget;
    btnC    = 1'b1;
    btn_raw = 4'b0;
    tick    = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    checkOutput("reset_sel",   32'(btn_sel),   32'd0);
    checkOutput("reset_press", 32'(btn_press), 32'd0);
    compareAll();
    btnC = 1'b0;
    repeat (3) applyStimulus(4'b0000, 1'b0);

    // Clean press on U: level and press appear together six edges later.
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(4'b0001, 1'b0);
      if (c == 5) checkOutput("u_level_early", 32'(btn_level[0]), 32'd0);
      if (c == 6) begin
        checkOutput("u_level_c6", 32'(btn_level[0]), 32'd1);
        checkOutput("u_press_c6", 32'(btn_press[0]), 32'd1);
      end
      if (c == 7) begin
        checkOutput("u_press_c7", 32'(btn_press), 32'd0);
        checkOutput("u_held_c7",  32'(btn_held),  32'b0001);
        checkOutput("u_valid_c7", 32'(btn_valid), 32'd1);
        checkOutput("u_sel_c7",   32'(btn_sel),   32'd0);
      end
    end
    repeat (8) applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("u_held_cleared", 32'(btn_held), 32'd0);

    // Short glitch on R is rejected.
    repeat (3) applyStimulus(4'b0100, 1'b0);
    repeat (8) applyStimulus(4'b0000, 1'b0);
    checkOutput("glitch_level", 32'(btn_level), 32'd0);
    checkOutput("glitch_held",  32'(btn_held),  32'd0);

    // L and R pressed together: both pending, L has priority, tick clears both.
    repeat (7) applyStimulus(4'b0110, 1'b0);
    checkOutput("lr_held", 32'(btn_held), 32'b0110);
    checkOutput("lr_sel",  32'(btn_sel),  32'd1);
    applyStimulus(4'b0110, 1'b1);
    checkOutput("lr_tick_clear", 32'(btn_held), 32'd0);
    repeat (8) applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b1);

    // D pending, second D press coincides with tick: event survives, no drop.
    repeat (7) applyStimulus(4'b1000, 1'b0);
    repeat (8) applyStimulus(4'b0000, 1'b0);
    checkOutput("d_pending", 32'(btn_held), 32'b1000);
    budget = 20;
    while (!m_press[3] && budget > 0) begin
      applyStimulus(4'b1000, 1'b0);
      budget--;
    end
    if (budget == 0) checkOutput("d_press_timeout", 32'd0, 32'd1);
    applyStimulus(4'b1000, 1'b1);
    checkOutput("d_tick_press_held", 32'(btn_held[3]), 32'd1);
    checkOutput("d_tick_press_drop", 32'(drop_cnt),    32'd0);
    repeat (8) applyStimulus(4'b0000, 1'b0);
    applyStimulus(4'b0000, 1'b1);

    // 17 presses on L without tick: drop counter saturates at 15.
    for (int p = 0; p < 17; p++) begin
      repeat (7) applyStimulus(4'b0010, 1'b0);
      repeat (7) applyStimulus(4'b0000, 1'b0);
    end
    checkOutput("sat_drop", 32'(drop_cnt), 32'd15);
    checkOutput("sat_held", 32'(btn_held), 32'b0010);

    // Reset mid-count while L is pending and still pressed: re-qualified.
    repeat (4) applyStimulus(4'b0010, 1'b0);
    resetDut();
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(4'b0010, 1'b0);
      if (c == 5) checkOutput("rq_press_c5", 32'(btn_press), 32'd0);
      if (c == 6) checkOutput("rq_press_c6", 32'(btn_press), 32'b0010);
    end
    repeat (8) applyStimulus(4'b0000, 1'b1);

    // Randomized stimulus: slow random toggling, random ticks, rare resets.
    rnd_raw = 4'b0;
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 9) == 0) rnd_raw[i] = ~rnd_raw[i];
      end
      if ($urandom_range(0, 149) == 0) begin
        btn_raw = rnd_raw;
        resetDut();
      end else begin
        applyStimulus(rnd_raw, ($urandom_range(0, 5) == 0));
      end
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
